// File: rtl/playfield_engine.sv
// Tetris playfield store: per-cell colour array with piece commit, full-row removal
// and downward compaction, plus combinational collision query and registered pixel read.
module playfield_engine #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int CW    = 24,
    parameter int CELLS = 4,
    localparam int RW   = $clog2(ROWS),
    localparam int CLW  = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_all,
    input  logic                 lock_valid,
    output logic                 lock_ready,
    input  logic [CELLS*RW-1:0]  lock_row,
    input  logic [CELLS*CLW-1:0] lock_col,
    input  logic [CW-1:0]        lock_color,
    input  logic [CELLS*RW-1:0]  chk_row,
    input  logic [CELLS*CLW-1:0] chk_col,
    output logic                 chk_hit,
    input  logic [RW-1:0]        rd_row,
    input  logic [CLW-1:0]       rd_col,
    output logic [CW-1:0]        rd_color,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           lines,
    output logic [9:0]           total_lines
);

    typedef enum logic [2:0] {IDLE, WRITE, COMPACT, FILL, DONE} state_t;

    localparam logic [RW:0]  ROW_LIM = (RW+1)'(ROWS);
    localparam logic [CLW:0] COL_LIM = (CLW+1)'(COLS);
    localparam logic [RW:0]  ROW_TOP = (RW+1)'(ROWS - 1);

    state_t state, next_state;

    logic [CW-1:0]        cells [ROWS][COLS];
    logic [CELLS*RW-1:0]  req_row;
    logic [CELLS*CLW-1:0] req_col;
    logic [CW-1:0]        req_color;
    logic [RW:0]          src, dst, cnt, cnt_next;
    logic                 src_full;
    logic                 accept;
    logic [10:0]          tot_sum;

    function automatic logic row_ok(input logic [RW-1:0] r);
        return {1'b0, r} < ROW_LIM;
    endfunction

    function automatic logic col_ok(input logic [CLW-1:0] c);
        return {1'b0, c} < COL_LIM;
    endfunction

    assign lock_ready = (state == IDLE) && !clear_all;
    assign busy       = (state != IDLE);
    assign accept     = lock_valid && lock_ready;
    assign cnt_next   = cnt + (RW+1)'(src_full);
    assign tot_sum    = {1'b0, total_lines} + 11'(cnt);

    always_comb begin
        src_full = 1'b0;
        if (src < ROW_LIM) begin
            src_full = 1'b1;
            for (int unsigned c = 0; c < COLS; c++) begin
                if (cells[src[RW-1:0]][c] == '0) src_full = 1'b0;
            end
        end
    end

    always_comb begin
        chk_hit = 1'b0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (!row_ok(chk_row[i*RW +: RW]) || !col_ok(chk_col[i*CLW +: CLW]))
                chk_hit = 1'b1;
            else if (cells[chk_row[i*RW +: RW]][chk_col[i*CLW +: CLW]] != '0)
                chk_hit = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = WRITE;
            WRITE:   next_state = COMPACT;
            COMPACT: if (src == '0) next_state = (cnt_next != '0) ? FILL : DONE;
            FILL:    if (dst == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (clear_all) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++)
                for (int unsigned c = 0; c < COLS; c++)
                    cells[r][c] <= '0;
            req_row     <= '0;
            req_col     <= '0;
            req_color   <= '0;
            src         <= '0;
            dst         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            lines       <= '0;
            total_lines <= '0;
            rd_color    <= '0;
        end else begin
            done     <= 1'b0;
            rd_color <= (row_ok(rd_row) && col_ok(rd_col)) ? cells[rd_row][rd_col] : '0;
            if (clear_all) begin
                for (int unsigned r = 0; r < ROWS; r++)
                    for (int unsigned c = 0; c < COLS; c++)
                        cells[r][c] <= '0;
                lines       <= '0;
                total_lines <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            req_row   <= lock_row;
                            req_col   <= lock_col;
                            req_color <= lock_color;
                        end
                    end
                    WRITE: begin
                        for (int unsigned i = 0; i < CELLS; i++) begin
                            if (row_ok(req_row[i*RW +: RW]) && col_ok(req_col[i*CLW +: CLW]))
                                cells[req_row[i*RW +: RW]][req_col[i*CLW +: CLW]] <= req_color;
                        end
                        src <= ROW_TOP;
                        dst <= ROW_TOP;
                        cnt <= '0;
                    end
                    COMPACT: begin
                        cnt <= cnt_next;
                        src <= src - 1'b1;
                        if (!src_full) begin
                            if (src != dst)
                                for (int unsigned c = 0; c < COLS; c++)
                                    cells[dst[RW-1:0]][c] <= cells[src[RW-1:0]][c];
                            dst <= dst - 1'b1;
                        end
                        // Reload dst for FILL directly so a board with every row full still empties
                        if (src == '0) dst <= cnt_next - 1'b1;
                    end
                    FILL: begin
                        for (int unsigned c = 0; c < COLS; c++)
                            cells[dst[RW-1:0]][c] <= '0;
                        dst <= dst - 1'b1;
                    end
                    DONE: begin
                        done        <= 1'b1;
                        lines       <= 3'(cnt);
                        total_lines <= (tot_sum > 11'd1023) ? 10'd1023 : tot_sum[9:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench for playfield_engine: default 10x20 board plus a 2x8 board used
// to reach total_lines saturation and abort a commit mid-FILL.
module tb_playfield_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear_all, lock_valid, lock_ready, chk_hit, busy, done;
    logic [19:0] lock_row, chk_row;
    logic [15:0] lock_col, chk_col;
    logic [23:0] lock_color, rd_color;
    logic [4:0]  rd_row;
    logic [3:0]  rd_col;
    logic [2:0]  lines;
    logic [9:0]  total_lines;

    logic        clear2, lock_valid2, lock_ready2, chk_hit2, busy2, done2;
    logic [23:0] lock_row2, chk_row2;
    logic [7:0]  lock_col2, chk_col2;
    logic [7:0]  lock_color2, rd_color2;
    logic [2:0]  rd_row2;
    logic [0:0]  rd_col2;
    logic [2:0]  lines2;
    logic [9:0]  total2;

    int errors = 0;
    int checks = 0;

    playfield_engine dut (
        .clk(clk), .rst_n(rst_n), .clear_all(clear_all),
        .lock_valid(lock_valid), .lock_ready(lock_ready),
        .lock_row(lock_row), .lock_col(lock_col), .lock_color(lock_color),
        .chk_row(chk_row), .chk_col(chk_col), .chk_hit(chk_hit),
        .rd_row(rd_row), .rd_col(rd_col), .rd_color(rd_color),
        .busy(busy), .done(done), .lines(lines), .total_lines(total_lines)
    );

    playfield_engine #(.COLS(2), .ROWS(8), .CW(8), .CELLS(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear_all(clear2),
        .lock_valid(lock_valid2), .lock_ready(lock_ready2),
        .lock_row(lock_row2), .lock_col(lock_col2), .lock_color(lock_color2),
        .chk_row(chk_row2), .chk_col(chk_col2), .chk_hit(chk_hit2),
        .rd_row(rd_row2), .rd_col(rd_col2), .rd_color(rd_color2),
        .busy(busy2), .done(done2), .lines(lines2), .total_lines(total2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int r, input int c, output logic [23:0] v);
        @(negedge clk);
        rd_row = 5'(r);
        rd_col = 4'(c);
        tick();
        v = rd_color;
    endtask

    task automatic rd2(input int r, input int c, output logic [7:0] v);
        @(negedge clk);
        rd_row2 = 3'(r);
        rd_col2 = 1'(c);
        tick();
        v = rd_color2;
    endtask

    task automatic set_chk(input int r0, c0, r1, c1, r2, c2, r3, c3);
        chk_row = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
        chk_col = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
        #1;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (lat < 200) begin
            tick();
            lat++;
            if (done) break;
        end
    endtask

    task automatic start(input int r0, c0, r1, c1, r2, c2, r3, c3, input logic [23:0] color);
        @(negedge clk);
        lock_row   = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
        lock_col   = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
        lock_color = color;
        lock_valid = 1'b1;
        tick();
        lock_valid = 1'b0;
    endtask

    task automatic commit(input int r0, c0, r1, c1, r2, c2, r3, c3, input logic [23:0] color,
                          output int lat);
        start(r0, c0, r1, c1, r2, c2, r3, c3, color);
        wait_done(0, lat);
    endtask

    // Covers rows base..base+nrows-1, both columns, repeating cells as needed.
    task automatic start2(input int base, input int nrows);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            lock_row2[i*3 +: 3] = 3'(base + (i / 2) % nrows);
            lock_col2[i]        = 1'(i % 2);
        end
        lock_color2 = 8'h5A;
        lock_valid2 = 1'b1;
        tick();
        lock_valid2 = 1'b0;
    endtask

    task automatic commit2(input int base, input int nrows, output int lat);
        start2(base, nrows);
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (done2) break;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] v;
        logic [7:0]  v2;
        int lat, bad, seen, k;

        rst_n = 1'b0; clear_all = 1'b0; lock_valid = 1'b0;
        lock_row = '0; lock_col = '0; lock_color = '0;
        chk_row = '0; chk_col = '0; rd_row = '0; rd_col = '0;
        clear2 = 1'b0; lock_valid2 = 1'b0; lock_row2 = '0; lock_col2 = '0;
        lock_color2 = '0; chk_row2 = '0; chk_col2 = '0; rd_row2 = '0; rd_col2 = '0;

        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lines", lines, 0);
        check("rst_total", total_lines, 0);
        check("rst_rd", rd_color, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", lock_ready, 1);

        // Single I piece on an empty board
        commit(19, 3, 19, 4, 19, 5, 19, 6, 24'h99FFCC, lat);
        check("i_lat", lat, 22);
        check("i_lines", lines, 0);
        rd(19, 4, v); check("i_rd_19_4", v, 24'h99FFCC);
        rd(19, 2, v); check("i_rd_19_2", v, 0);
        rd(19, 6, v); check("i_rd_19_6", v, 24'h99FFCC);

        set_chk(19, 6, 0, 0, 0, 1, 0, 2);  check("chk_occ", chk_hit, 1);
        set_chk(19, 2, 0, 0, 0, 1, 0, 2);  check("chk_free", chk_hit, 0);
        set_chk(19, 2, 0, 10, 0, 1, 0, 2); check("chk_col10", chk_hit, 1);
        set_chk(20, 2, 0, 0, 0, 1, 0, 2);  check("chk_row20", chk_hit, 1);

        // Single-line clear with a marker dropping one row
        @(negedge clk);
        clear_all = 1'b1;
        #1;
        check("clr_ready", lock_ready, 0);
        tick();
        clear_all = 1'b0;
        check("clr_total", total_lines, 0);
        rd(19, 4, v); check("clr_rd", v, 0);
        commit(19, 0, 19, 1, 19, 2, 19, 3, 24'h111111, lat);
        commit(19, 4, 19, 5, 18, 0, 18, 0, 24'h222222, lat);
        commit(19, 6, 19, 7, 19, 8, 19, 9, 24'h333333, lat);
        check("l1_lat", lat, 23);
        check("l1_lines", lines, 1);
        check("l1_total", total_lines, 1);
        rd(19, 0, v); check("l1_marker", v, 24'h222222);
        rd(19, 1, v); check("l1_rd_19_1", v, 0);
        rd(18, 0, v); check("l1_rd_18_0", v, 0);
        rd(0, 0, v);  check("l1_top_0", v, 0);
        rd(19, 9, v); check("l1_rd_19_9", v, 0);

        // Requests held while busy must not start a second commit
        start(0, 0, 0, 1, 0, 2, 0, 3, 24'h444444);
        lock_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_ready", lock_ready, 0);
            check("busy_flag", busy, 1);
            tick();
        end
        lock_valid = 1'b0;
        wait_done(4, lat);
        check("busy_lat", lat, 22);
        check("busy_lines", lines, 0);
        repeat (3) tick();
        check("busy_single", busy, 0);
        set_chk(0, 4, 0, 5, 1, 0, 1, 1); check("chk_empty", chk_hit, 0);
        set_chk(0, 4, 0, 5, 0, 2, 1, 1); check("chk_top", chk_hit, 1);

        // Four-line clear: rows 16..19 filled except col 9, then vertical I
        @(negedge clk);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("l4_clr_total", total_lines, 0);
        bad = 0;
        for (int p = 0; p < 9; p++) begin
            k = 4 * p;
            commit(16 + k / 9, k % 9, 16 + (k + 1) / 9, (k + 1) % 9,
                   16 + (k + 2) / 9, (k + 2) % 9, 16 + (k + 3) / 9, (k + 3) % 9,
                   24'h0000AA, lat);
            if (lat != 22 || lines != 0) bad++;
        end
        check("l4_prefill", bad, 0);
        set_chk(16, 9, 17, 9, 18, 9, 19, 9); check("l4_chk_col9", chk_hit, 0);
        set_chk(16, 0, 17, 9, 18, 9, 19, 9); check("l4_chk_full", chk_hit, 1);
        commit(16, 9, 17, 9, 18, 9, 19, 9, 24'h777777, lat);
        check("l4_lat", lat, 26);
        check("l4_lines", lines, 4);
        check("l4_total", total_lines, 4);
        rd(16, 0, v); check("l4_rd_16_0", v, 0);
        rd(19, 8, v); check("l4_rd_19_8", v, 0);
        rd(19, 9, v); check("l4_rd_19_9", v, 0);
        set_chk(16, 0, 17, 0, 18, 0, 19, 0); check("l4_chk_empty", chk_hit, 0);

        // Saturation on the small board: 511 two-line clears then a four-line clear
        bad = 0;
        for (int n = 0; n < 511; n++) begin
            commit2(6, 2, lat);
            if (lat != 12 || lines2 != 2) bad++;
        end
        check("sat_runs", bad, 0);
        check("sat_1022", total2, 1022);
        commit2(4, 4, lat);
        check("sat_lat", lat, 14);
        check("sat_lines", lines2, 4);
        check("sat_1023", total2, 1023);

        // clear_all during FILL aborts with no done pulse
        start2(6, 2);
        repeat (9) tick();
        check("fill_busy", busy2, 1);
        @(negedge clk);
        clear2 = 1'b1;
        tick();
        clear2 = 1'b0;
        check("abort_busy", busy2, 0);
        check("abort_done", done2, 0);
        check("abort_lines", lines2, 0);
        check("abort_total", total2, 0);
        seen = 0;
        repeat (20) begin
            tick();
            if (done2) seen++;
        end
        check("abort_nodone", seen, 0);
        check("abort_ready", lock_ready2, 1);
        rd2(7, 0, v2); check("abort_rd_7_0", v2, 0);
        rd2(6, 1, v2); check("abort_rd_6_1", v2, 0);

        // Asynchronous reset in the middle of COMPACT
        @(negedge clk);
        rd_row = 5'd19;
        rd_col = 4'd0;
        start(19, 0, 19, 1, 19, 2, 19, 3, 24'h555555);
        repeat (5) tick();
        check("mid_busy", busy, 1);
        check("mid_rd", rd_color, 24'h555555);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_total", total_lines, 0);
        check("areset_lines", lines, 0);
        check("areset_rd", rd_color, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("areset_ready", lock_ready, 1);
        rd(19, 0, v); check("areset_cell", v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
